// File: rtl/instr_loader.sv
// Boot-time program loader: parses a framed byte stream, writes little-endian
// words to instruction memory from address 0, verifies an XOR checksum, then releases the CPU.
module instr_loader #(
  parameter int unsigned IMEM_AWIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'(32'd1 << IMEM_AWIDTH);

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] words_q, words_d;
  logic [23:0] buf_q, buf_d;
  logic [7:0]  acc_q, acc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic [15:0] len_new;
  logic [15:0] words_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_SYNC;
      len_q      <= '0;
      byte_idx_q <= '0;
      words_q    <= '0;
      buf_q      <= '0;
      acc_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      words_q    <= words_d;
      buf_q      <= buf_d;
      acc_q      <= acc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Ready is gated by rst so nothing is handshaken while reset is asserted.
  assign s_ready   = rst && (state_q != S_DONE) && (state_q != S_ERR);
  assign accept    = s_valid && s_ready;
  assign len_new   = {s_data, len_q[7:0]};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    words_d    = words_q;
    buf_d      = buf_q;
    acc_d      = acc_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (accept) begin
      unique case (state_q)
        S_SYNC: begin
          if (s_data == 8'hA5) state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = s_data;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = s_data;
          if (len_new == 16'd0 || {1'b0, len_new} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = '0;
            words_d    = '0;
            acc_d      = '0;
          end
        end
        S_DATA: begin
          acc_d      = acc_q ^ s_data;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: buf_d[7:0]   = s_data;
            2'd1: buf_d[15:8]  = s_data;
            2'd2: buf_d[23:16] = s_data;
            2'd3: begin
              wdata_d = {s_data, buf_q};
              addr_d  = {14'd0, words_q, 2'b00};
              we_d    = 1'b1;
              words_d = words_inc;
              if (words_inc == len_q) state_d = S_CHK;
            end
          endcase
        end
        S_CHK: begin
          state_d = (s_data == acc_q) ? S_DONE : S_ERR;
        end
        default: ;
      endcase
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign load_done    = (state_q == S_DONE);
  assign cpu_rst      = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign words_loaded = words_q;

endmodule
